// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the 5-stage RV32I pipeline.
// Priority per cycle: rst > Redirect > Stall > normal fetch; saturating stall/flush profiling counters.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Stall,
    input  logic             Redirect,
    input  logic [31:0]      RedirectPC,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      ID_pc,
    output logic [31:0]      ID_pc4,
    output logic [31:0]      ID_instr,
    output logic             ID_valid,
    output logic             misalign,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic [31:0]      pc_p0;
    logic [31:0]      id_pc_p1;
    logic [31:0]      id_instr_p1;
    logic             vld_p1;
    logic             misalign_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // IF stage: PC register; IF/ID boundary: id_*_p1 / vld_p1
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_p0       <= RESET_PC;
            id_pc_p1    <= 32'h0;
            id_instr_p1 <= NOP_INSTR;
            vld_p1      <= 1'b0;
            misalign_q  <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (Redirect) begin
            // The word fetched this cycle belongs to the wrong path and is dropped.
            pc_p0       <= {RedirectPC[31:2], 2'b00};
            id_pc_p1    <= 32'h0;
            id_instr_p1 <= NOP_INSTR;
            vld_p1      <= 1'b0;
            flush_cnt_q <= sat_inc(flush_cnt_q);
            if (RedirectPC[1:0] != 2'b00)
                misalign_q <= 1'b1;
        end else if (Stall) begin
            stall_cnt_q <= sat_inc(stall_cnt_q);
        end else begin
            pc_p0       <= pc_p0 + 32'd4;
            id_pc_p1    <= pc_p0;
            id_instr_p1 <= imem_rdata;
            vld_p1      <= 1'b1;
        end
    end

    assign imem_addr = pc_p0;
    assign ID_pc     = id_pc_p1;
    assign ID_pc4    = id_pc_p1 + 32'd4;
    assign ID_instr  = id_instr_p1;
    assign ID_valid  = vld_p1;
    assign misalign  = misalign_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
